// File: rtl/gmem_rr_scheduler.sv
// gmem_rr_scheduler: round-robin grant for the shared memory bus, with a lock mechanism that
// times out and a read-valid strobe that arrives one cycle after the granted read.
module gmem_rr_scheduler #(
    parameter int NUM_CORES       = 8,
    parameter int ID_WIDTH        = $clog2(NUM_CORES),
    parameter int MAX_LOCK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] request,
    input  logic [NUM_CORES-1:0] is_read,
    input  logic [NUM_CORES-1:0] lock,
    output logic [NUM_CORES-1:0] grant_oh,
    output logic [ID_WIDTH-1:0]  grant_id,
    output logic                 grant_valid,
    output logic [NUM_CORES-1:0] read_valid_oh,
    output logic                 lock_timeout
);
    localparam logic [0:0] ARB    = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    localparam int CW = $clog2(MAX_LOCK_CYCLES);

    logic [0:0]           state_q, state_d;
    logic [ID_WIDTH-1:0]  ptr_q, ptr_d, owner_q, owner_d, winner, sel, sel_inc;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_CORES-1:0] rv_q, rv_d;
    logic                 to_q, to_d, found, none;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!found && request[(int'(ptr_q) + k) % NUM_CORES]) begin
                found  = 1'b1;
                winner = ID_WIDTH'((int'(ptr_q) + k) % NUM_CORES);
            end
        end
        sel         = (state_q == LOCKED) ? owner_q : winner;
        sel_inc     = (sel == ID_WIDTH'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
        // While locked the owner keeps the mux even when idle, so grant_oh is not gated by found.
        none        = reset || (state_q == ARB && !found);
        grant_oh    = none ? '0 : NUM_CORES'(1) << sel;
        grant_id    = none ? '0 : sel;
        grant_valid = !reset && ((state_q == LOCKED) ? request[owner_q] : found);
        rv_d        = (grant_valid && is_read[grant_id]) ? grant_oh : '0;
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        to_d        = 1'b0;
        if (state_q == ARB) begin
            if (found) begin
                ptr_d = sel_inc;
                if (lock[winner]) begin
                    state_d = LOCKED;
                    owner_d = winner;
                    cnt_d   = CW'(1);
                end
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (!lock[owner_q] || cnt_q == CW'(MAX_LOCK_CYCLES - 1)) begin
                state_d = ARB;
                ptr_d   = sel_inc;
                cnt_d   = '0;
                to_d    = lock[owner_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            rv_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            to_q    <= to_d;
        end
    end

    assign read_valid_oh = rv_q;
    assign lock_timeout  = to_q;
endmodule

// File: tb/tb_gmem_rr_scheduler.sv
// tb_gmem_rr_scheduler: directed scenarios for the round-robin bus scheduler.
module tb_gmem_rr_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] request = '0, is_read = '0, lock = '0;
    logic [7:0] grant_oh, read_valid_oh;
    logic [2:0] grant_id;
    logic       grant_valid, lock_timeout;
    int checks = 0, failures = 0;

    gmem_rr_scheduler #(.NUM_CORES(8), .ID_WIDTH(3), .MAX_LOCK_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .request(request), .is_read(is_read), .lock(lock),
        .grant_oh(grant_oh), .grant_id(grant_id), .grant_valid(grant_valid),
        .read_valid_oh(read_valid_oh), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task cyc(input logic [7:0] r, input logic [7:0] rd, input logic [7:0] lk);
        @(negedge clk);
        request = r;
        is_read = rd;
        lock    = lk;
        #1;
    endtask

    task do_reset();
        @(negedge clk);
        reset = 1'b1;
        request = '0; is_read = '0; lock = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task test_reset();
        @(negedge clk);
        reset = 1'b1;
        request = 8'hFF; is_read = 8'hFF; lock = 8'hFF;
        #1;
        checks++; if (grant_oh !== 8'h00) begin failures++; $display("FAIL reset_grant_oh got=%h exp=00", grant_oh); end
        checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_grant_valid got=%b exp=0", grant_valid); end
        @(negedge clk);
        reset = 1'b0;
        request = '0; is_read = '0; lock = '0;
        #1;
        checks++; if (read_valid_oh !== 8'h00) begin failures++; $display("FAIL reset_read_valid got=%h exp=00", read_valid_oh); end
        checks++; if (lock_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", lock_timeout); end
        checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL idle_grant_valid got=%b exp=0", grant_valid); end
    endtask

    task test_all_request();
        logic [7:0] exp_rv;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(8'hFF, 8'h55, 8'h00);
            checks++; if (grant_oh !== (8'h01 << (i % 8))) begin failures++; $display("FAIL rr_grant_oh[%0d] got=%h exp=%h", i, grant_oh, 8'h01 << (i % 8)); end
            checks++; if (grant_id !== 3'(i % 8)) begin failures++; $display("FAIL rr_grant_id[%0d] got=%0d exp=%0d", i, grant_id, i % 8); end
            checks++; if (grant_valid !== 1'b1) begin failures++; $display("FAIL rr_grant_valid[%0d] got=%b exp=1", i, grant_valid); end
            if (i > 0) begin
                exp_rv = ((i - 1) % 2 == 0) ? (8'h01 << ((i - 1) % 8)) : 8'h00;
                checks++; if (read_valid_oh !== exp_rv) begin failures++; $display("FAIL rr_read_valid[%0d] got=%h exp=%h", i, read_valid_oh, exp_rv); end
            end
        end
    endtask

    task test_single();
        do_reset();
        cyc(8'h20, 8'h20, 8'h00);
        checks++; if (grant_oh !== 8'h20) begin failures++; $display("FAIL single_grant got=%h exp=20", grant_oh); end
        checks++; if (grant_id !== 3'd5) begin failures++; $display("FAIL single_id got=%0d exp=5", grant_id); end
        cyc(8'h41, 8'h00, 8'h00);
        checks++; if (grant_oh !== 8'h40) begin failures++; $display("FAIL single_ptr6 got=%h exp=40", grant_oh); end
        checks++; if (read_valid_oh !== 8'h20) begin failures++; $display("FAIL single_read_valid got=%h exp=20", read_valid_oh); end
        cyc(8'h00, 8'h00, 8'h00);
        checks++; if (read_valid_oh !== 8'h00) begin failures++; $display("FAIL write_no_strobe got=%h exp=00", read_valid_oh); end
    endtask

    task test_lock_release();
        do_reset();
        cyc(8'h0C, 8'h00, 8'h04);
        checks++; if (grant_oh !== 8'h04) begin failures++; $display("FAIL lock_c0 got=%h exp=04", grant_oh); end
        cyc(8'h08, 8'h00, 8'h04);
        checks++; if (grant_oh !== 8'h04) begin failures++; $display("FAIL lock_c1_owner_idle got=%h exp=04", grant_oh); end
        checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL lock_c1_valid got=%b exp=0", grant_valid); end
        cyc(8'h0C, 8'h00, 8'h00);
        checks++; if (grant_oh !== 8'h04) begin failures++; $display("FAIL lock_c2 got=%h exp=04", grant_oh); end
        checks++; if (grant_valid !== 1'b1) begin failures++; $display("FAIL lock_c2_valid got=%b exp=1", grant_valid); end
        cyc(8'h0C, 8'h00, 8'h00);
        checks++; if (grant_oh !== 8'h08) begin failures++; $display("FAIL lock_release_next got=%h exp=08", grant_oh); end
        checks++; if (lock_timeout !== 1'b0) begin failures++; $display("FAIL lock_release_timeout got=%b exp=0", lock_timeout); end
    endtask

    task test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(8'h06, 8'h00, 8'h02);
            checks++; if (grant_oh !== 8'h02) begin failures++; $display("FAIL to_owned[%0d] got=%h exp=02", i, grant_oh); end
            checks++; if (lock_timeout !== 1'b0) begin failures++; $display("FAIL to_early[%0d] got=%b exp=0", i, lock_timeout); end
        end
        cyc(8'h06, 8'h00, 8'h02);
        checks++; if (grant_oh !== 8'h04) begin failures++; $display("FAIL to_next_grant got=%h exp=04", grant_oh); end
        checks++; if (lock_timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", lock_timeout); end
        cyc(8'h06, 8'h00, 8'h02);
        checks++; if (grant_oh !== 8'h02) begin failures++; $display("FAIL to_wrap_grant got=%h exp=02", grant_oh); end
        checks++; if (lock_timeout !== 1'b0) begin failures++; $display("FAIL to_single_pulse got=%b exp=0", lock_timeout); end
    endtask

    task test_reset_mid_lock();
        do_reset();
        cyc(8'h40, 8'h00, 8'h40);
        cyc(8'h41, 8'h00, 8'h40);
        checks++; if (grant_oh !== 8'h40) begin failures++; $display("FAIL rml_locked got=%h exp=40", grant_oh); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (grant_oh !== 8'h00) begin failures++; $display("FAIL rml_grant_in_reset got=%h exp=00", grant_oh); end
        checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL rml_valid_in_reset got=%b exp=0", grant_valid); end
        @(negedge clk);
        reset = 1'b0;
        lock = 8'h00;
        #1;
        checks++; if (grant_oh !== 8'h01) begin failures++; $display("FAIL rml_core0_wins got=%h exp=01", grant_oh); end
        checks++; if (lock_timeout !== 1'b0) begin failures++; $display("FAIL rml_timeout got=%b exp=0", lock_timeout); end
        cyc(8'h00, 8'h00, 8'h00);
        checks++; if (lock_timeout !== 1'b0) begin failures++; $display("FAIL rml_timeout_late got=%b exp=0", lock_timeout); end
    endtask

    task test_wrap();
        do_reset();
        cyc(8'h80, 8'h80, 8'h00);
        checks++; if (grant_id !== 3'd7) begin failures++; $display("FAIL wrap_id7 got=%0d exp=7", grant_id); end
        cyc(8'h00, 8'h00, 8'h00);
        checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle_valid got=%b exp=0", grant_valid); end
        checks++; if (grant_oh !== 8'h00) begin failures++; $display("FAIL wrap_idle_grant got=%h exp=00", grant_oh); end
        checks++; if (read_valid_oh !== 8'h80) begin failures++; $display("FAIL wrap_read_valid got=%h exp=80", read_valid_oh); end
        cyc(8'h81, 8'h00, 8'h00);
        checks++; if (grant_oh !== 8'h01) begin failures++; $display("FAIL wrap_ptr0 got=%h exp=01", grant_oh); end
        checks++; if (read_valid_oh !== 8'h00) begin failures++; $display("FAIL wrap_no_strobe got=%h exp=00", read_valid_oh); end
    endtask

    initial begin
        test_reset();
        test_all_request();
        test_single();
        test_lock_release();
        test_timeout();
        test_reset_mid_lock();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
